mmu_mem_responder: RTL and testbench
====================================

// Module: mmu_mem_responder
// PURPOSE
// Memory-side responder for the MMU's physical MEM_* interface: accepts one-cycle read/write pulses on the
// TRANS, INST and DATA channels and serialises them onto a single request/ack backing bus.
// Returns ROADDR/RVALID/RDATA per read channel and drives MEM_WAIT back to the MMU.
// Sits between the MMU and the memory/interconnect.
// PARAMETERS
// TIMEOUT   255           max BUS_ACK wait cycles per access; 0 = no timeout
// ERR_DATA  32'h0000_0000 RDATA returned for a timed-out read
// PORTS
// CLK               in   1   clock, rising edge
// RST               in   1   asynchronous reset, active-low
// MEM_TRANS_RDEN    in   1   translation read pulse
// MEM_TRANS_RIADDR  in   32  translation read address
// MEM_TRANS_ROADDR  out  32  address of returned translation data
// MEM_TRANS_RVALID  out  1   translation read data valid (1 cycle)
// MEM_TRANS_RDATA   out  32  translation read data
// MEM_INST_RDEN/RIADDR/ROADDR/RVALID/RDATA  same as TRANS, instruction channel
// MEM_DATA_RDEN/RIADDR/ROADDR/RVALID/RDATA  same as TRANS, data read channel
// MEM_DATA_WREN     in   1   data write pulse
// MEM_DATA_WSTRB    in   4   byte strobes
// MEM_DATA_WADDR    in   32  write address
// MEM_DATA_WDATA    in   32  write data
// MEM_WAIT          out  1   responder busy; MMU must not pulse requests
// BUS_REQ           out  1   backing-bus request, held until BUS_ACK
// BUS_WE            out  1   1 = write access
// BUS_ADDR          out  32  word address, {addr[31:2],2'b00}
// BUS_WSTRB         out  4   write strobes (0 on reads)
// BUS_WDATA         out  32  write data
// BUS_ACK           in   1   access complete this cycle
// BUS_RDATA         in   32  read data, valid with BUS_ACK
// TIMEOUT_ERR       out  1   1-cycle pulse when an access times out
// BEHAVIOUR
// - Reset (RST low, async): state IDLE, pending bits cleared, all outputs 0; abandons any bus access.
// - States IDLE, ISSUE, RESP. Request strobes sampled only in IDLE and RESP; strobes in ISSUE ignored.
// - Sample: each asserted strobe latches its address (and WSTRB/WDATA) into its own pending slot;
//   all four channels may pulse in one cycle. Any latched -> ISSUE, else IDLE.
// - ISSUE: serve highest-priority pending slot: TRANS > DATA write > DATA read > INST (write before read
//   so same-cycle read returns new data). BUS_REQ=1 with that slot's fields, stable until BUS_ACK.
// - BUS_ACK: read slot captures BUS_RDATA, slot cleared; next slot issued next cycle (BUS_REQ drops 1 cycle);
//   no slots left -> RESP.
// - Timeout: counter resets per access; after TIMEOUT cycles without ACK, slot completes with ERR_DATA,
//   BUS_REQ drops, TIMEOUT_ERR pulses 1 cycle. TIMEOUT=0 disables; ACK in the expiry cycle wins.
// - RESP (1 cycle): RVALID=1 on each read channel completed this batch, ROADDR = original RIADDR
//   (unaligned, unmodified), RDATA = captured data. Writes produce no RVALID. ROADDR/RDATA hold after.
// - MEM_WAIT = (state==ISSUE), registered; low in IDLE and RESP.
// - Latency: pulse in cycle N, 0-wait ACK -> MEM_WAIT high N+1, RVALID N+2. Each extra slot adds 2 cycles,
//   each ACK wait cycle adds 1.
// TESTING
// - INST pulse addr 0x0000_1002, ACK same cycle, RDATA 0x0000_0013 -> BUS_ADDR 0x1000, INST_RVALID at N+2,
//   ROADDR 0x1002, RDATA 0x13.
// - TRANS+INST+DATA R+W pulsed together -> bus order TRANS, WRITE, READ, INST; single RESP with 3 RVALIDs.
// - Write 0xDEADBEEF WSTRB 4'b0011 to 0x2000 + read 0x2000 same cycle -> write issued first, no RVALID for it.
// - BUS_ACK held low, TIMEOUT=4 -> after 4 cycles TIMEOUT_ERR pulse, RVALID with RDATA=ERR_DATA.
// - RST low during ISSUE with BUS_ACK pending -> BUS_REQ, MEM_WAIT, RVALIDs 0 immediately; next pulse served.
// - Strobe pulsed while MEM_WAIT high -> ignored, no extra bus access.

Source files
------------

// File: rtl/mmu_mem_responder.sv
// Memory-side responder for the MMU MEM_* interface.
// Serialises TRANS/DATA-write/DATA-read/INST pulses onto one req/ack bus.
module mmu_mem_responder #(
   parameter int unsigned TIMEOUT  = 255,
   parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        mem_trans_rden_i,
   input  logic [31:0] mem_trans_riaddr_i,
   output logic [31:0] mem_trans_roaddr_o,
   output logic        mem_trans_rvalid_o,
   output logic [31:0] mem_trans_rdata_o,
   input  logic        mem_inst_rden_i,
   input  logic [31:0] mem_inst_riaddr_i,
   output logic [31:0] mem_inst_roaddr_o,
   output logic        mem_inst_rvalid_o,
   output logic [31:0] mem_inst_rdata_o,
   input  logic        mem_data_rden_i,
   input  logic [31:0] mem_data_riaddr_i,
   output logic [31:0] mem_data_roaddr_o,
   output logic        mem_data_rvalid_o,
   output logic [31:0] mem_data_rdata_o,
   input  logic        mem_data_wren_i,
   input  logic [3:0]  mem_data_wstrb_i,
   input  logic [31:0] mem_data_waddr_i,
   input  logic [31:0] mem_data_wdata_i,
   output logic        mem_wait_o,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [3:0]  bus_wstrb_o,
   output logic [31:0] bus_wdata_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        timeout_err_o
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   // Slot index is also the issue priority; channel c maps to SLOT[c].
   localparam logic [1:0] SLOT [3] = '{2'd0, 2'd3, 2'd2};

   logic [1:0]    state_q, state_d;
   logic [3:0]    pend_q, pend_d;
   logic [31:0]   addr_q [4];
   logic [31:0]   addr_d [4];
   logic [31:0]   cap_q [4];
   logic [31:0]   cap_d [4];
   logic [3:0]    wstrb_q, wstrb_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    done_q, done_d;
   logic          gap_q, gap_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tmo_q, tmo_d;
   logic          wait_q;
   logic [2:0]    rv_q, rv_d;
   logic [31:0]   roaddr_q [3];
   logic [31:0]   roaddr_d [3];
   logic [31:0]   rdata_q [3];
   logic [31:0]   rdata_d [3];

   logic [3:0]  stb;
   logic [31:0] ad [4];
   logic [1:0]  sel;
   logic        req;
   logic        expire;
   logic        fin;

   assign stb   = {mem_inst_rden_i, mem_data_rden_i,
                   mem_data_wren_i, mem_trans_rden_i};
   assign ad[0] = mem_trans_riaddr_i;
   assign ad[1] = mem_data_waddr_i;
   assign ad[2] = mem_data_riaddr_i;
   assign ad[3] = mem_inst_riaddr_i;

   always_comb begin
      sel = 2'd0;
      if (pend_q[0])      sel = 2'd0;
      else if (pend_q[1]) sel = 2'd1;
      else if (pend_q[2]) sel = 2'd2;
      else if (pend_q[3]) sel = 2'd3;
   end

   assign req    = (state_q == S_ISSUE) && !gap_q && (pend_q != 4'd0);
   assign expire = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
   assign fin    = req && (bus_ack_i || expire);

   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      addr_d   = addr_q;
      cap_d    = cap_q;
      wstrb_d  = wstrb_q;
      wdata_d  = wdata_q;
      done_d   = done_q;
      gap_d    = 1'b0;
      cnt_d    = cnt_q;
      tmo_d    = 1'b0;
      rv_d     = 3'd0;
      roaddr_d = roaddr_q;
      rdata_d  = rdata_q;
      unique case (1'b1)
         (state_q == S_ISSUE): begin
            if (fin) begin
               pend_d[sel] = 1'b0;
               done_d[sel] = 1'b1;
               cap_d[sel]  = bus_ack_i ? bus_rdata_i : ERR_DATA;
               cnt_d       = '0;
               tmo_d       = ~bus_ack_i;
               if (pend_d == 4'd0) begin
                  state_d = S_RESP;
                  for (int c = 0; c < 3; c++) begin
                     if (done_d[SLOT[c]]) begin
                        rv_d[c]     = 1'b1;
                        roaddr_d[c] = addr_q[SLOT[c]];
                        rdata_d[c]  = cap_d[SLOT[c]];
                     end
                  end
               end else begin
                  gap_d = 1'b1;
               end
            end else if (req) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            done_d = 4'd0;
            cnt_d  = '0;
            for (int i = 0; i < 4; i++) begin
               if (stb[i]) begin
                  pend_d[i] = 1'b1;
                  addr_d[i] = ad[i];
               end
            end
            if (mem_data_wren_i) begin
               wstrb_d = mem_data_wstrb_i;
               wdata_d = mem_data_wdata_i;
            end
            state_d = (stb != 4'd0) ? S_ISSUE : S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         pend_q   <= 4'd0;
         addr_q   <= '{default: '0};
         cap_q    <= '{default: '0};
         wstrb_q  <= 4'd0;
         wdata_q  <= 32'd0;
         done_q   <= 4'd0;
         gap_q    <= 1'b0;
         cnt_q    <= '0;
         tmo_q    <= 1'b0;
         wait_q   <= 1'b0;
         rv_q     <= 3'd0;
         roaddr_q <= '{default: '0};
         rdata_q  <= '{default: '0};
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         addr_q   <= addr_d;
         cap_q    <= cap_d;
         wstrb_q  <= wstrb_d;
         wdata_q  <= wdata_d;
         done_q   <= done_d;
         gap_q    <= gap_d;
         cnt_q    <= cnt_d;
         tmo_q    <= tmo_d;
         wait_q   <= (state_d == S_ISSUE);
         rv_q     <= rv_d;
         roaddr_q <= roaddr_d;
         rdata_q  <= rdata_d;
      end
   end

   assign mem_wait_o    = wait_q;
   assign timeout_err_o = tmo_q;
   assign bus_req_o     = req;
   assign bus_we_o      = req && (sel == 2'd1);
   assign bus_addr_o    = req ? {addr_q[sel][31:2], 2'b00} : 32'd0;
   assign bus_wstrb_o   = (req && sel == 2'd1) ? wstrb_q : 4'd0;
   assign bus_wdata_o   = req ? wdata_q : 32'd0;

   assign mem_trans_rvalid_o = rv_q[0];
   assign mem_inst_rvalid_o  = rv_q[1];
   assign mem_data_rvalid_o  = rv_q[2];
   assign mem_trans_roaddr_o = roaddr_q[0];
   assign mem_inst_roaddr_o  = roaddr_q[1];
   assign mem_data_roaddr_o  = roaddr_q[2];
   assign mem_trans_rdata_o  = rdata_q[0];
   assign mem_inst_rdata_o   = rdata_q[1];
   assign mem_data_rdata_o   = rdata_q[2];

endmodule

// File: tb/tb_mmu_mem_responder.sv
// Bench for mmu_mem_responder: transaction-queue reference model,
// per-cycle compare, directed literal checks and random traffic.
module tb_mmu_mem_responder;

   localparam int          TO  = 4;
   localparam logic [31:0] ERR = 32'hBAD0_0BAD;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic tr_rden = 0, in_rden = 0, dr_rden = 0, dw_wren = 0;
   logic [31:0] tr_a = 0, in_a = 0, dr_a = 0, dw_a = 0, dw_d = 0;
   logic [3:0]  dw_s = 0;
   logic        ack = 0;
   logic [31:0] brdata = 0;
   logic [31:0] tr_ro, in_ro, dr_ro, tr_rd, in_rd, dr_rd;
   logic        tr_rv, in_rv, dr_rv;
   logic        mwait, breq, bwe, tmo;
   logic [31:0] baddr, bwdata;
   logic [3:0]  bwstrb;

   mmu_mem_responder #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .mem_trans_rden_i(tr_rden), .mem_trans_riaddr_i(tr_a),
      .mem_trans_roaddr_o(tr_ro), .mem_trans_rvalid_o(tr_rv),
      .mem_trans_rdata_o(tr_rd),
      .mem_inst_rden_i(in_rden), .mem_inst_riaddr_i(in_a),
      .mem_inst_roaddr_o(in_ro), .mem_inst_rvalid_o(in_rv),
      .mem_inst_rdata_o(in_rd),
      .mem_data_rden_i(dr_rden), .mem_data_riaddr_i(dr_a),
      .mem_data_roaddr_o(dr_ro), .mem_data_rvalid_o(dr_rv),
      .mem_data_rdata_o(dr_rd),
      .mem_data_wren_i(dw_wren), .mem_data_wstrb_i(dw_s),
      .mem_data_waddr_i(dw_a), .mem_data_wdata_i(dw_d),
      .mem_wait_o(mwait), .bus_req_o(breq), .bus_we_o(bwe),
      .bus_addr_o(baddr), .bus_wstrb_o(bwstrb), .bus_wdata_o(bwdata),
      .bus_ack_i(ack), .bus_rdata_i(brdata), .timeout_err_o(tmo)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          ch;
      bit          we;
      logic [31:0] addr;
      logic [3:0]  s;
      logic [31:0] d;
   } acc_t;

   int n_cmp = 0;
   int n_bad = 0;

   acc_t        q[$];
   logic [32:0] blog[$];
   bit          m_busy, m_gap, m_tmo;
   int          m_wcnt;
   int          dly;
   bit [2:0]    m_rv, m_done;
   logic [31:0] m_ra [3];
   logic [31:0] m_rd [3];
   logic [31:0] m_cap [3];
   logic [31:0] m_adr [3];

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      q.delete();
      m_busy = 0; m_gap = 0; m_tmo = 0; m_wcnt = 0;
      m_rv = 0; m_done = 0;
      for (int c = 0; c < 3; c++) begin
         m_ra[c] = 0; m_rd[c] = 0; m_cap[c] = 0; m_adr[c] = 0;
      end
   endfunction

   task automatic check_outputs();
      bit er;
      er = m_busy && !m_gap;
      chk("mem_wait", mwait, m_busy);
      chk("bus_req", breq, er);
      chk("timeout_err", tmo, m_tmo);
      chk("rvalid", {dr_rv, in_rv, tr_rv}, m_rv);
      chk("trans_roaddr", tr_ro, m_ra[0]);
      chk("inst_roaddr", in_ro, m_ra[1]);
      chk("data_roaddr", dr_ro, m_ra[2]);
      chk("trans_rdata", tr_rd, m_rd[0]);
      chk("inst_rdata", in_rd, m_rd[1]);
      chk("data_rdata", dr_rd, m_rd[2]);
      if (er) begin
         chk("bus_we", bwe, q[0].we);
         chk("bus_addr", baddr, {q[0].addr[31:2], 2'b00});
         chk("bus_wstrb", bwstrb, q[0].we ? q[0].s : 4'd0);
         if (q[0].we) chk("bus_wdata", bwdata, q[0].d);
      end
   endtask

   function automatic void model_step();
      m_tmo = 0;
      m_rv  = 0;
      if (m_busy) begin
         if (m_gap) begin
            m_gap = 0;
         end else if (ack || m_wcnt == TO - 1) begin
            if (q[0].ch >= 0) begin
               m_cap[q[0].ch]  = ack ? brdata : ERR;
               m_adr[q[0].ch]  = q[0].addr;
               m_done[q[0].ch] = 1;
            end
            m_tmo = !ack;
            void'(q.pop_front());
            m_wcnt = 0;
            if (q.size() == 0) begin
               m_busy = 0;
               m_rv = m_done;
               for (int c = 0; c < 3; c++) begin
                  if (m_done[c]) begin
                     m_ra[c] = m_adr[c];
                     m_rd[c] = m_cap[c];
                  end
               end
            end else begin
               m_gap = 1;
            end
         end else begin
            m_wcnt++;
         end
      end else begin
         m_done = 0;
         if (tr_rden) q.push_back('{0, 1'b0, tr_a, 4'd0, 32'd0});
         if (dw_wren) q.push_back('{-1, 1'b1, dw_a, dw_s, dw_d});
         if (dr_rden) q.push_back('{2, 1'b0, dr_a, 4'd0, 32'd0});
         if (in_rden) q.push_back('{1, 1'b0, in_a, 4'd0, 32'd0});
         m_busy = (q.size() != 0);
         m_wcnt = 0;
         m_gap  = 0;
      end
   endfunction

   task automatic cycle();
      check_outputs();
      ack = m_busy && !m_gap && (m_wcnt >= dly);
      if (ack && breq) blog.push_back({bwe, baddr});
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic idle_strobes();
      tr_rden = 0; in_rden = 0; dr_rden = 0; dw_wren = 0;
   endtask

   task automatic run_to_resp(output int k);
      k = 0;
      while (!(m_rv != 0 && !m_busy) && k < 40) begin
         cycle();
         k++;
      end
      if (k >= 40) begin
         n_cmp++; n_bad++;
         $display("FAIL resp_wait: got timeout want response");
      end
   endtask

   initial begin
      int k;
      model_reset();
      dly = 0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_wait", mwait, 0);
      chk("rst_req", breq, 0);
      chk("rst_rv", {dr_rv, in_rv, tr_rv}, 0);
      chk("rst_roaddr", in_ro, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // single instruction fetch, zero-wait ack
      in_rden = 1; in_a = 32'h0000_1002; brdata = 32'h13;
      cycle();
      idle_strobes();
      chk("t1_wait", mwait, 1);
      chk("t1_req", breq, 1);
      chk("t1_addr", baddr, 32'h0000_1000);
      cycle();
      chk("t1_rvalid", in_rv, 1);
      chk("t1_roaddr", in_ro, 32'h0000_1002);
      chk("t1_rdata", in_rd, 32'h13);
      chk("t1_wait_lo", mwait, 0);
      cycle();
      chk("t1_rv_drop", in_rv, 0);
      chk("t1_hold", in_rd, 32'h13);

      // all channels together, write before read
      blog.delete();
      tr_rden = 1; tr_a = 32'h0000_3004;
      dw_wren = 1; dw_a = 32'h0000_2000; dw_d = 32'hDEAD_BEEF; dw_s = 4'b0011;
      dr_rden = 1; dr_a = 32'h0000_2000;
      in_rden = 1; in_a = 32'h0000_1002;
      brdata = 32'h55;
      cycle();
      idle_strobes();
      run_to_resp(k);
      chk("t2_latency", k, 7);
      chk("t2_rvalid", {dr_rv, in_rv, tr_rv}, 3'b111);
      chk("t2_nacc", blog.size(), 4);
      if (blog.size() == 4) begin
         chk("t2_acc0", blog[0], {1'b0, 32'h0000_3004});
         chk("t2_acc1", blog[1], {1'b1, 32'h0000_2000});
         chk("t2_acc2", blog[2], {1'b0, 32'h0000_2000});
         chk("t2_acc3", blog[3], {1'b0, 32'h0000_1000});
      end
      chk("t2_trans_rdata", tr_rd, 32'h55);
      chk("t2_trans_roaddr", tr_ro, 32'h0000_3004);
      cycle();

      // timeout with a strobe pulsed while busy
      dly = 100;
      in_rden = 1; in_a = 32'h0000_1100;
      cycle();
      idle_strobes();
      tr_rden = 1; tr_a = 32'h0000_7000;
      cycle();
      idle_strobes();
      repeat (3) cycle();
      chk("t4_tmo", tmo, 1);
      chk("t4_rvalid", in_rv, 1);
      chk("t4_rdata", in_rd, ERR);
      chk("t4_trans_rv", tr_rv, 0);
      chk("t4_req", breq, 0);
      cycle();
      chk("t4_tmo_drop", tmo, 0);
      chk("t4_no_extra", mwait, 0);

      // async reset during an outstanding access
      in_rden = 1; in_a = 32'h0000_1200;
      cycle();
      idle_strobes();
      cycle();
      chk("t5_req_pre", breq, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_req", breq, 0);
      chk("t5_wait", mwait, 0);
      chk("t5_rv", {dr_rv, in_rv, tr_rv}, 0);
      ack = 0;
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      dly = 0;
      dr_rden = 1; dr_a = 32'h0000_0044; brdata = 32'hCAFE_0001;
      cycle();
      idle_strobes();
      cycle();
      chk("t5_rvalid", dr_rv, 1);
      chk("t5_rdata", dr_rd, 32'hCAFE_0001);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if (m_wcnt == 0) dly = $urandom_range(0, 5);
         tr_rden = ($urandom_range(0, 3) == 0);
         in_rden = ($urandom_range(0, 3) == 0);
         dr_rden = ($urandom_range(0, 3) == 0);
         dw_wren = ($urandom_range(0, 3) == 0);
         tr_a = $urandom; in_a = $urandom; dr_a = $urandom;
         dw_a = $urandom; dw_d = $urandom; dw_s = 4'($urandom);
         brdata = $urandom;
         cycle();
      end
      idle_strobes();
      repeat (40) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
